// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and its datapath.
// master = control unit, slave = datapath / memory side.
interface multicycle_control_if #(
  parameter int INSTRET_W = 32
);
  logic [6:0]           opcode;
  logic                 mem_ready;
  logic                 IorD;
  logic                 MemRead;
  logic                 MemWrite;
  logic                 IRWrite;
  logic                 PCWrite;
  logic                 PCWriteCond;
  logic                 PCSource;
  logic                 ALUSrcA;
  logic [1:0]           ALUSrcB;
  logic [1:0]           ALUOperation;
  logic                 RegWrite;
  logic                 MemtoReg;
  logic                 retire;
  logic [INSTRET_W-1:0] instret;
  logic                 illegal_instr;
  logic [3:0]           state;

  modport master (
    input  opcode, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, PCWrite,
    output PCWriteCond, PCSource, ALUSrcA, ALUSrcB,
    output ALUOperation, RegWrite, MemtoReg, retire,
    output instret, illegal_instr, state
  );

  modport slave (
    output opcode, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, PCWrite,
    input  PCWriteCond, PCSource, ALUSrcA, ALUSrcB,
    input  ALUOperation, RegWrite, MemtoReg, retire,
    input  instret, illegal_instr, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM with retired-instruction counter.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes instead of refetching.
module multicycle_control #(
  parameter int INSTRET_W = 32
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_control_if.master bus
);

  localparam logic [3:0] FETCH     = 4'd0;
  localparam logic [3:0] DECODE    = 4'd1;
  localparam logic [3:0] MEM_ADDR  = 4'd2;
  localparam logic [3:0] MEM_READ  = 4'd3;
  localparam logic [3:0] MEM_WRITE = 4'd4;
  localparam logic [3:0] WB_MEM    = 4'd5;
  localparam logic [3:0] EXEC_R    = 4'd6;
  localparam logic [3:0] EXEC_I    = 4'd7;
  localparam logic [3:0] WB_ALU    = 4'd8;
  localparam logic [3:0] BRANCH    = 4'd9;
  localparam logic [3:0] TRAP      = 4'd10;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [3:0]           state_q;
  logic [3:0]           state_d;
  logic [INSTRET_W-1:0] instret_q;
  logic                 retire;

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:
        if (bus.mem_ready) state_d = DECODE;
      DECODE:
        case (bus.opcode)
          OP_LOAD, OP_STORE: state_d = MEM_ADDR;
          OP_REG:            state_d = EXEC_R;
          OP_IMM:            state_d = EXEC_I;
          OP_BRANCH:         state_d = BRANCH;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = TRAP;
`else
          default:           state_d = FETCH;
`endif
        endcase
      MEM_ADDR:
        state_d = (bus.opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
      MEM_READ:
        if (bus.mem_ready) state_d = WB_MEM;
      MEM_WRITE:
        if (bus.mem_ready) state_d = FETCH;
      EXEC_R, EXEC_I:
        state_d = WB_ALU;
      WB_MEM, WB_ALU, BRANCH:
        state_d = FETCH;
`ifdef ILLEGAL_TRAP_EN
      TRAP:
        state_d = TRAP;
`endif
      default:
        state_d = FETCH;
    endcase
  end

  // Everything is forced low while reset is held, even though FETCH is live.
  always_comb begin
    bus.IorD         = 1'b0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    bus.IRWrite      = 1'b0;
    bus.PCWrite      = 1'b0;
    bus.PCWriteCond  = 1'b0;
    bus.PCSource     = 1'b0;
    bus.ALUSrcA      = 1'b0;
    bus.ALUSrcB      = 2'b00;
    bus.ALUOperation = 2'b00;
    bus.RegWrite     = 1'b0;
    bus.MemtoReg     = 1'b0;
    retire           = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'b01;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        DECODE:
          bus.ALUSrcB = 2'b10;
        MEM_ADDR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'b10;
        end
        MEM_READ: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        MEM_WRITE: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
          retire       = bus.mem_ready;
        end
        WB_MEM: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
          retire       = 1'b1;
        end
        EXEC_R: begin
          bus.ALUSrcA      = 1'b1;
          bus.ALUOperation = 2'b10;
        end
        EXEC_I: begin
          bus.ALUSrcA      = 1'b1;
          bus.ALUSrcB      = 2'b10;
          bus.ALUOperation = 2'b11;
        end
        WB_ALU: begin
          bus.RegWrite = 1'b1;
          retire       = 1'b1;
        end
        BRANCH: begin
          bus.ALUSrcA      = 1'b1;
          bus.ALUOperation = 2'b01;
          bus.PCWriteCond  = 1'b1;
          bus.PCSource     = 1'b1;
          retire           = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal_instr = !reset && (state_q == TRAP);
`else
  assign bus.illegal_instr = 1'b0;
`endif

  assign bus.retire  = retire;
  assign bus.instret = instret_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control (INSTRET_W=4 to reach wrap).
// Expected traces are built per instruction class from the state table.
module tb_multicycle_control;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  int   retired = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.INSTRET_W(W)) bus ();

  multicycle_control #(.INSTRET_W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;

  function automatic logic [6:0] opc_of(input int k);
    case (k)
      K_R:     return 7'b0110011;
      K_I:     return 7'b0010011;
      K_LD:    return 7'b0000011;
      K_ST:    return 7'b0100011;
      K_BR:    return 7'b1100011;
      default: return 7'b1111111;
    endcase
  endfunction

  // {IorD,MemRead,MemWrite,IRWrite,PCWrite,PCWriteCond,PCSource,ALUSrcA,
  //  ALUSrcB,ALUOperation,RegWrite,MemtoReg,retire,illegal_instr}
  function automatic logic [15:0] exp_out(input int s, input logic r);
    logic iord, mr, mw, irw, pcw, pcc, pcs, asa, rw, mtr, ret, ill;
    logic [1:0] asb, aop;
    {iord, mr, mw, irw, pcw, pcc, pcs, asa, rw, mtr, ret, ill} = '0;
    asb = 2'b00;
    aop = 2'b00;
    case (s)
      0:  begin mr = 1; asb = 2'b01; irw = r; pcw = r; end
      1:  asb = 2'b10;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; iord = 1; end
      4:  begin mw = 1; iord = 1; ret = r; end
      5:  begin rw = 1; mtr = 1; ret = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin asa = 1; asb = 2'b10; aop = 2'b11; end
      8:  begin rw = 1; ret = 1; end
      9:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 1; ret = 1; end
      10: ill = 1;
      default: ;
    endcase
    return {iord, mr, mw, irw, pcw, pcc, pcs, asa, asb, aop, rw, mtr, ret, ill};
  endfunction

  function automatic logic [15:0] dut_out();
    return {bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite, bus.PCWrite,
            bus.PCWriteCond, bus.PCSource, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUOperation, bus.RegWrite, bus.MemtoReg, bus.retire,
            bus.illegal_instr};
  endfunction

  task automatic chk_state(input string tag, input logic [3:0] e);
    tests++;
    assert (bus.state === e) else begin
      fails++;
      $error("FAIL %s state: got %0d want %0d", tag, bus.state, e);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] e);
    tests++;
    assert (dut_out() === e) else begin
      fails++;
      $error("FAIL %s outputs: got %h want %h", tag, dut_out(), e);
    end
  endtask

  task automatic chk_instret(input string tag);
    logic [W-1:0] e;
    e = W'(retired % (1 << W));
    tests++;
    assert (bus.instret === e) else begin
      fails++;
      $error("FAIL %s instret: got %0d want %0d", tag, bus.instret, e);
    end
  endtask

  // One clock cycle in a known state; opcode only matters in states 1 and 2.
  task automatic cyc(input string tag, input int st, input logic rdy,
                     input logic [6:0] opc);
    logic [15:0] e;
    @(negedge clk);
    mem_drive(rdy, (st == 1 || st == 2) ? opc : 7'($urandom));
    #1;
    e = exp_out(st, rdy);
    chk_state(tag, 4'(st));
    chk_out(tag, e);
    chk_instret(tag);
    if (e[1]) retired++;
  endtask

  task automatic mem_drive(input logic rdy, input logic [6:0] opc);
    bus.mem_ready = rdy;
    bus.opcode    = opc;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1;
    mem_drive(1'b1, 7'($urandom));
    #1;
    retired = 0;
    chk_state(tag, 4'd0);
    chk_out(tag, 16'h0000);
    chk_instret(tag);
    @(posedge clk);
    #1;
    chk_state(tag, 4'd0);
    reset = 1'b0;
  endtask

  task automatic fetch_decode(input string tag, input int fs, input int k);
    for (int i = 0; i < fs; i++) cyc(tag, 0, 1'b0, 7'd0);
    cyc(tag, 0, 1'b1, 7'd0);
    cyc(tag, 1, 1'($urandom), opc_of(k));
  endtask

  task automatic run_instr(input string tag, input int k, input int fs,
                           input int ms);
    logic [6:0] op;
    op = opc_of(k);
    fetch_decode(tag, fs, k);
    case (k)
      K_R:  begin cyc(tag, 6, 1'($urandom), op); cyc(tag, 8, 1'($urandom), op); end
      K_I:  begin cyc(tag, 7, 1'($urandom), op); cyc(tag, 8, 1'($urandom), op); end
      K_LD: begin
        cyc(tag, 2, 1'($urandom), op);
        for (int i = 0; i < ms; i++) cyc(tag, 3, 1'b0, op);
        cyc(tag, 3, 1'b1, op);
        cyc(tag, 5, 1'($urandom), op);
      end
      K_ST: begin
        cyc(tag, 2, 1'($urandom), op);
        for (int i = 0; i < ms; i++) cyc(tag, 4, 1'b0, op);
        cyc(tag, 4, 1'b1, op);
      end
      K_BR: cyc(tag, 9, 1'($urandom), op);
      default: begin
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++) cyc(tag, 10, 1'($urandom), op);
        do_reset("trap_reset");
`endif
      end
    endcase
  endtask

  initial begin
    reset = 1'b1;
    mem_drive(1'b0, 7'd0);
    #3;
    chk_state("reset", 4'd0);
    chk_out("reset", 16'h0000);
    chk_instret("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_instr("rtype_wrap", K_R, 0, 0);
    @(negedge clk);
    tests++;
    assert (bus.instret === 4'd0) else begin
      fails++;
      $error("FAIL wrap16 instret: got %0d want 0", bus.instret);
    end

    run_instr("itype", K_I, 1, 0);
    run_instr("load_stall3", K_LD, 2, 3);
    run_instr("branch", K_BR, 0, 0);
    run_instr("store", K_ST, 1, 2);

    fetch_decode("store_rst", 0, K_ST);
    cyc("store_rst", 2, 1'b0, opc_of(K_ST));
    cyc("store_rst", 4, 1'b0, opc_of(K_ST));
    do_reset("store_rst");

    run_instr("illegal", K_ILL, 0, 0);
    chk_instret("illegal_after");
    run_instr("after_ill", K_R, 0, 0);

    for (int n = 0; n < 60; n++)
      run_instr("random", int'($urandom_range(0, 5)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
